// File: rtl/spi_ram.sv
// spi_ram: single-port synchronous memory driven by 10-bit SPI command words.
// Each accepted word is decoded by din[9:8] into write-address, write-data,
// read-address or read-data. Write and read addresses live in separate
// auto-incrementing registers; read data is returned with a one-cycle
// tx_valid pulse.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   synchronous active-low reset
//   din       in  10   command word {opcode[1:0], payload[7:0]}
//   rx_valid  in   1   din holds a command this cycle
//   dout      out  8   last read data (held between reads)
//   tx_valid  out  1   one-cycle pulse, dout carries new read data
//   cmd_err   out  1   sticky: data command issued before its address
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  // State encoding is {rd_addr_ok, wr_addr_ok}.
  typedef enum logic [1:0] {
    NO_ADDR = 2'b00,
    WADDR   = 2'b01,
    RADDR   = 2'b10,
    BOTH    = 2'b11
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [7:0] mem [MEM_DEPTH];

  state_t                 state_reg, state_next;
  logic [ADDR_SIZE-1:0]   wr_addr_reg, wr_addr_next;
  logic [ADDR_SIZE-1:0]   rd_addr_reg, rd_addr_next;
  logic [7:0]             dout_reg;
  logic                   tx_valid_reg;
  logic                   cmd_err_reg;
  logic                   wr_en;
  logic                   rd_en;
  logic                   err_set;

  always_comb begin
    state_next   = state_reg;
    wr_addr_next = wr_addr_reg;
    rd_addr_next = rd_addr_reg;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    err_set      = 1'b0;
    if (rx_valid) begin
      case (din[9:8])
        OP_WR_ADDR: begin
          wr_addr_next = din[ADDR_SIZE-1:0];
          // Address-loaded flags are only ever set here, never cleared.
          state_next   = state_t'(state_reg | WADDR);
        end
        OP_WR_DATA: begin
          if (state_reg[0]) begin
            wr_en        = 1'b1;
            wr_addr_next = wr_addr_reg + ADDR_SIZE'(1);
          end else begin
            err_set = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          rd_addr_next = din[ADDR_SIZE-1:0];
          state_next   = state_t'(state_reg | RADDR);
        end
        default: begin // OP_RD_DATA
          if (state_reg[1]) begin
            rd_en        = 1'b1;
            rd_addr_next = rd_addr_reg + ADDR_SIZE'(1);
          end else begin
            err_set = 1'b1;
          end
        end
      endcase
    end
  end

  // Memory is never reset; a command coincident with reset must not write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_addr_reg] <= din[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= NO_ADDR;
      wr_addr_reg  <= '0;
      rd_addr_reg  <= '0;
      dout_reg     <= 8'h00;
      tx_valid_reg <= 1'b0;
      cmd_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_addr_reg  <= wr_addr_next;
      rd_addr_reg  <= rd_addr_next;
      tx_valid_reg <= rd_en;
      if (rd_en) begin
        dout_reg <= mem[rd_addr_reg];
      end
      if (err_set) begin
        cmd_err_reg <= 1'b1;
      end
    end
  end

  assign dout     = dout_reg;
  assign tx_valid = tx_valid_reg;
  assign cmd_err  = cmd_err_reg;

endmodule

// File: tb/tb_spi_ram.sv
// Directed testbench for spi_ram: drives commands on the falling edge and
// checks registered outputs on the following falling edge.
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] WD = 2'b01;
  localparam logic [1:0] RA = 2'b10;
  localparam logic [1:0] RD = 2'b11;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Present one command; rx_valid stays high until idle() so commands chain.
  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    @(negedge clk);
    rx_valid = 1'b1;
    din      = {op, pl};
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single read: RD_DATA then check the pulse and data one cycle later.
  task automatic read_one(input string tag, input logic [7:0] exp);
    cmd(RD, 8'h00);
    idle();
    check_val({tag, "_txv"}, 32'(tx_valid), 32'd1);
    check_val({tag, "_dout"}, 32'(dout), 32'(exp));
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = '0;

    // Plain reset
    do_reset(2);
    check_val("rst_dout", 32'(dout), 32'h00);
    check_val("rst_txv", 32'(tx_valid), 32'd0);
    check_val("rst_err", 32'(cmd_err), 32'd0);

    // Reset with an armed write pending: 0xAA must keep 0x55
    cmd(WA, 8'hAA);
    cmd(WD, 8'h55);
    cmd(WA, 8'hAA);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    din      = 10'h1AA;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    check_val("rst2_dout", 32'(dout), 32'h00);
    check_val("rst2_txv", 32'(tx_valid), 32'd0);
    check_val("rst2_err", 32'(cmd_err), 32'd0);
    cmd(RA, 8'hAA);
    read_one("rst2_mem", 8'h55);

    // Basic write/read, one-cycle pulse, dout holds
    cmd(WA, 8'h10);
    cmd(WD, 8'h5C);
    cmd(RA, 8'h10);
    @(negedge clk);
    check_val("basic_pre_txv", 32'(tx_valid), 32'd0);
    rx_valid = 1'b1;
    din      = {RD, 8'h00};
    idle();
    check_val("basic_txv", 32'(tx_valid), 32'd1);
    check_val("basic_dout", 32'(dout), 32'h5C);
    @(negedge clk);
    check_val("basic_txv_drop", 32'(tx_valid), 32'd0);
    check_val("basic_hold", 32'(dout), 32'h5C);

    // Burst write with wrap, back-to-back reads
    cmd(WA, 8'hFE);
    cmd(WD, 8'h11);
    cmd(WD, 8'h22);
    cmd(WD, 8'h33);
    cmd(RA, 8'hFE);
    cmd(RD, 8'h00);
    cmd(RD, 8'h00);
    check_val("burst0_txv", 32'(tx_valid), 32'd1);
    check_val("burst0_dout", 32'(dout), 32'h11);
    cmd(RD, 8'h00);
    check_val("burst1_txv", 32'(tx_valid), 32'd1);
    check_val("burst1_dout", 32'(dout), 32'h22);
    idle();
    check_val("burst2_txv", 32'(tx_valid), 32'd1);
    check_val("burst2_dout", 32'(dout), 32'h33);
    @(negedge clk);
    check_val("burst_end_txv", 32'(tx_valid), 32'd0);
    check_val("burst_err", 32'(cmd_err), 32'd0);

    // Error path
    do_reset(1);
    cmd(RD, 8'h00);
    idle();
    check_val("err_rd_txv", 32'(tx_valid), 32'd0);
    check_val("err_rd_flag", 32'(cmd_err), 32'd1);
    check_val("err_rd_dout", 32'(dout), 32'h00);
    cmd(WD, 8'h77);
    idle();
    repeat (3) @(negedge clk);
    check_val("err_sticky", 32'(cmd_err), 32'd1);
    do_reset(1);
    check_val("err_cleared", 32'(cmd_err), 32'd0);
    cmd(RA, 8'h00);
    read_one("err_mem0", 8'h33);
    check_val("err_none", 32'(cmd_err), 32'd0);

    // Independence of write and read addresses
    cmd(WA, 8'h40);
    cmd(WD, 8'h9D);
    cmd(WA, 8'h20);
    cmd(RA, 8'h40);
    cmd(WD, 8'hAB);
    read_one("indep_rd40", 8'h9D);
    cmd(RA, 8'h20);
    read_one("indep_rd20", 8'hAB);

    // Idle gaps with garbage on din: no state changes
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      din      = 10'($urandom);
      if (i > 0) check_val($sformatf("idle%0d_txv", i), 32'(tx_valid), 32'd0);
    end
    check_val("idle_dout", 32'(dout), 32'hAB);
    check_val("idle_err", 32'(cmd_err), 32'd0);
    // Both addresses should now be 0x21; write then immediate read
    cmd(WD, 8'hC3);
    read_one("idle_wr_rd", 8'hC3);

    // Reset between write burst words
    cmd(WA, 8'h50);
    cmd(WD, 8'h01);
    do_reset(1);
    cmd(WD, 8'h02);
    idle();
    check_val("mid_err", 32'(cmd_err), 32'd1);
    cmd(RA, 8'h50);
    read_one("mid_mem50", 8'h01);
    check_val("mid_err_hold", 32'(cmd_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
